// File: rtl/cpu_ram_loader.sv
// rtl/cpu_ram_loader.sv - 256x8 CPU RAM with LED/switch MMIO and a byte-stream program loader
module cpu_ram_loader #(
    parameter logic [7:0]  OUT_ADDR    = 8'hFF,
    parameter logic [7:0]  IN_ADDR     = 8'hFE,
    parameter logic [23:0] HOLD_CYCLES = 24'd1000000
) (
    input  logic       clk_qzt,
    input  logic       reset,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    input  logic [7:0] ld_data,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic       cpu_reset,
    output logic [7:0] cpu_res_addr,
    output logic       loading,
    output logic       ld_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_LEN,
        S_DATA,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [7:0]  start_q;
    logic [7:0]  cnt_q;
    logic [7:0]  ptr_q;
    logic [23:0] hold_q;
    logic [7:0]  res_addr_q;
    logic        cpu_reset_q;
    logic        ld_ready_q;
    logic        loading_q;
    logic        ld_error_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  led_q;

    logic [7:0]  mem_q [0:255];

    logic        ld_accept;
    logic        cpu_wr_ok;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;

    assign ld_accept = ld_valid && ld_ready_q;
    assign cpu_wr_ok = cpu_we && !loading_q;

    assign cpu_rdata    = cpu_rdata_q;
    assign led_out      = led_q;
    assign ld_ready     = ld_ready_q;
    assign cpu_reset    = cpu_reset_q;
    assign cpu_res_addr = res_addr_q;
    assign loading      = loading_q;
    assign ld_error     = ld_error_q;

    // Loader writes every cell, including the two MMIO-shadowed ones; the CPU never writes those.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_wdata;
        if (!reset) begin
            if (state_q == S_DATA && ld_accept) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = ld_data;
            end else if (cpu_wr_ok && cpu_addr != OUT_ADDR && cpu_addr != IN_ADDR) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_qzt) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            cpu_rdata_q <= 8'h00;
            led_q       <= 8'h00;
        end else begin
            if (cpu_addr == IN_ADDR) begin
                cpu_rdata_q <= sw_in;
            end else if (cpu_addr == OUT_ADDR) begin
                cpu_rdata_q <= led_q;
            end else begin
                cpu_rdata_q <= mem_q[cpu_addr];
            end
            if (cpu_wr_ok && cpu_addr == OUT_ADDR) begin
                led_q <= cpu_wdata;
            end
        end
    end

    // Registered outputs are assigned alongside the state they belong to, so they track state_q exactly.
    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 8'h00;
            cnt_q       <= 8'h00;
            ptr_q       <= 8'h00;
            hold_q      <= 24'd0;
            res_addr_q  <= 8'hFF;
            cpu_reset_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            loading_q   <= 1'b0;
            ld_error_q  <= 1'b0;
        end else begin
            ld_error_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    ld_ready_q  <= 1'b1;
                    loading_q   <= 1'b0;
                    cpu_reset_q <= 1'b0;
                    if (ld_accept) begin
                        start_q     <= ld_data;
                        // CPU comes out of reset with PC <= res_addr + 1
                        res_addr_q  <= ld_data - 8'd1;
                        cpu_reset_q <= 1'b1;
                        loading_q   <= 1'b1;
                        state_q     <= S_GET_LEN;
                    end
                end
                S_GET_LEN: begin
                    if (ld_accept) begin
                        if (ld_data == 8'h00) begin
                            ld_error_q  <= 1'b1;
                            cpu_reset_q <= 1'b0;
                            loading_q   <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            cnt_q   <= ld_data;
                            ptr_q   <= start_q;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (ld_accept) begin
                        ptr_q <= ptr_q + 8'd1;
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            hold_q     <= HOLD_CYCLES;
                            ld_ready_q <= 1'b0;
                            state_q    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == 24'd0) begin
                        cpu_reset_q <= 1'b0;
                        loading_q   <= 1'b0;
                        ld_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        hold_q <= hold_q - 24'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ram_loader.sv
// tb/tb_cpu_ram_loader.sv - directed vector bench for cpu_ram_loader
module tb_cpu_ram_loader;

    localparam logic [23:0] HOLD = 24'd20;
    localparam int BOUND = 200;

    logic       clk_qzt = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_addr = 8'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_rdata;
    logic [7:0] ld_data = 8'h00;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [7:0] sw_in = 8'h00;
    logic [7:0] led_out;
    logic       cpu_reset;
    logic [7:0] cpu_res_addr;
    logic       loading;
    logic       ld_error;

    int checks = 0;
    int errors = 0;

    cpu_ram_loader #(
        .OUT_ADDR(8'hFF),
        .IN_ADDR(8'hFE),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_qzt(clk_qzt),
        .reset(reset),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata),
        .ld_data(ld_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .sw_in(sw_in),
        .led_out(led_out),
        .cpu_reset(cpu_reset),
        .cpu_res_addr(cpu_res_addr),
        .loading(loading),
        .ld_error(ld_error)
    );

    always #5 clk_qzt = ~clk_qzt;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] sw;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_qzt);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        ld_data  = b;
        ld_valid = 1'b1;
        @(negedge clk_qzt);
        while (!ld_ready && n < BOUND) begin
            @(negedge clk_qzt);
            n++;
        end
        if (!ld_ready) begin
            chk("send_timeout", 32'(n), 32'(BOUND + 1));
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (cpu_reset && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 8'h06, 8'h00};
        vecs[1]  = '{1'b0, 8'h11, 8'h00, 8'h00, 1'b1, 8'h2A, 8'h00};
        vecs[2]  = '{1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 8'h76, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hC3, 8'h00};
        vecs[4]  = '{1'b0, 8'hFE, 8'h00, 8'h3C, 1'b1, 8'h3C, 8'h00};
        vecs[5]  = '{1'b0, 8'hFF, 8'h00, 8'h3C, 1'b1, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 8'hFF, 8'h5A, 8'h00, 1'b1, 8'h00, 8'h5A};
        vecs[7]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h5A, 8'h5A};
        vecs[8]  = '{1'b0, 8'hFE, 8'h00, 8'hC3, 1'b1, 8'hC3, 8'h5A};
        vecs[9]  = '{1'b1, 8'hFE, 8'h77, 8'hC3, 1'b1, 8'hC3, 8'h5A};
        vecs[10] = '{1'b0, 8'hFE, 8'h00, 8'h11, 1'b1, 8'h11, 8'h5A};
        vecs[11] = '{1'b0, 8'hFF, 8'h00, 8'h11, 1'b1, 8'h5A, 8'h5A};
        vecs[12] = '{1'b0, 8'h30, 8'h00, 8'h00, 1'b1, 8'h11, 8'h5A};
        vecs[13] = '{1'b0, 8'h31, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h5A};
        vecs[14] = '{1'b0, 8'h32, 8'h00, 8'h00, 1'b1, 8'h5A, 8'h5A};
        vecs[15] = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 8'h55, 8'h5A};
        vecs[16] = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b1, 8'h00, 8'h5A};
        vecs[17] = '{1'b1, 8'h05, 8'h77, 8'h00, 1'b0, 8'h00, 8'h5A};
        vecs[18] = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 8'h77, 8'h5A};

        repeat (3) tick();
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
        reset = 1'b0;
        tick();
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("post_rst_res_addr", 32'(cpu_res_addr), 32'hFF);
        chk("post_rst_led", 32'(led_out), 32'h00);
        chk("post_rst_loading", 32'(loading), 32'd0);
        chk("post_rst_ld_error", 32'(ld_error), 32'd0);

        send(8'h10);
        chk("a_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("a_res_addr", 32'(cpu_res_addr), 32'h0F);
        chk("a_loading", 32'(loading), 32'd1);
        send(8'h03);
        send(8'h06);
        send(8'h2A);
        send(8'h76);
        chk("a_hold_ready", 32'(ld_ready), 32'd0);
        wait_idle(n);
        chk("a_hold_len_ok", 32'(n >= int'(HOLD) && n <= int'(HOLD) + 1), 32'd1);
        chk("a_idle_ready", 32'(ld_ready), 32'd1);
        chk("a_idle_loading", 32'(loading), 32'd0);

        send(8'hFE);
        send(8'h03);
        send(8'hA1);
        send(8'hB2);
        send(8'hC3);
        wait_idle(n);
        chk("b_res_addr", 32'(cpu_res_addr), 32'hFD);

        send(8'h20);
        send(8'h00);
        chk("c_ld_error", 32'(ld_error), 32'd1);
        chk("c_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("c_loading", 32'(loading), 32'd0);
        chk("c_res_addr", 32'(cpu_res_addr), 32'h1F);
        tick();
        chk("c_ld_error_gone", 32'(ld_error), 32'd0);
        chk("c_ld_ready", 32'(ld_ready), 32'd1);

        cpu_write(8'h31, 8'hA5);
        cpu_write(8'h32, 8'h5A);
        send(8'h30);
        send(8'h03);
        send(8'h11);
        reset = 1'b1;
        tick();
        chk("d_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        reset = 1'b0;
        tick();
        chk("d_ld_ready", 32'(ld_ready), 32'd1);
        chk("d_loading", 32'(loading), 32'd0);
        chk("d_res_addr", 32'(cpu_res_addr), 32'hFF);

        cpu_write(8'h41, 8'h00);
        send(8'h40);
        send(8'h01);
        send(8'h55);
        ld_data  = 8'h99;
        ld_valid = 1'b1;
        cpu_write(8'h41, 8'hEE);
        for (int i = 0; i < 3; i++) begin
            chk("e_hold_ready", 32'(ld_ready), 32'd0);
            chk("e_hold_cpu_reset", 32'(cpu_reset), 32'd1);
            tick();
        end
        send(8'h99);
        chk("e_res_addr", 32'(cpu_res_addr), 32'h98);
        chk("e_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h00);
        chk("e_ld_error", 32'(ld_error), 32'd1);
        tick();

        for (int i = 0; i < 19; i++) begin
            cpu_we    = vecs[i].we;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            sw_in     = vecs[i].sw;
            tick();
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_rdata", i), 32'(cpu_rdata), 32'(vecs[i].exp_rd));
            end
            chk($sformatf("vec%0d_led", i), 32'(led_out), 32'(vecs[i].exp_led));
        end
        cpu_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
